// File: rtl/cpu_pkg.sv
// Shared ISA constants, ALU operation encoding and decoded-control types
// used by the decode stage and its instruction decoder.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_fields_t;

  // dest_is_rd selects rd over rt as the write target; uses_rt marks
  // instructions that actually read rt (relevant to load-use detection).
  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    branch;
    alu_op_e alu_op;
    logic    dest_is_rd;
    logic    uses_rt;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational decode of a 32-bit instruction into fields, control
// signals and an illegal flag; illegal encodings yield all-zero controls.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [31:0]   instr,
  output instr_fields_t fields,
  output ctrl_t         ctrl,
  output logic          illegal
);

  assign fields = instr;

  always_comb begin
    ctrl    = CTRL_NOP;
    illegal = 1'b0;
    case (fields.opcode)
      OP_RTYPE: begin
        ctrl.reg_write  = 1'b1;
        ctrl.dest_is_rd = 1'b1;
        ctrl.uses_rt    = 1'b1;
        case (fields.funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: begin
            ctrl    = CTRL_NOP;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_LW: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src   = 1'b1;
      end
      OP_SW: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        ctrl.branch  = 1'b1;
        ctrl.alu_op  = ALU_SUB;
        ctrl.uses_rt = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: register-file read, write-back bypass, load-use
// stall, flush and a fully registered output towards execute.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       in_instr,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] read_addr_1,
  output logic [ADDR_W-1:0] read_addr_2,
  input  logic [DATA_W-1:0] read_data_1,
  input  logic [DATA_W-1:0] read_data_2,
  input  logic              wb_reg_write,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [ADDR_W-1:0] out_dest,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write,
  output logic              out_alu_src,
  output logic              out_branch,
  output logic [2:0]        out_alu_op,
  output logic              out_illegal
);

  typedef struct packed {
    logic              valid;
    logic              illegal;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] dest;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              alu_src;
    logic              branch;
    alu_op_e           alu_op;
  } out_t;

  instr_fields_t     f;
  ctrl_t             ctrl;
  logic              illegal;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] dest_c;
  logic [15:0]       imm16;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              hold;
  logic              load_use;
  out_t              out_q;
  out_t              out_d;

  instr_decoder u_dec (
    .instr   (in_instr),
    .fields  (f),
    .ctrl    (ctrl),
    .illegal (illegal)
  );

  assign rs_addr     = ADDR_W'(f.rs);
  assign rt_addr     = ADDR_W'(f.rt);
  assign rd_addr     = ADDR_W'(f.rd);
  assign imm16       = {f.rd, f.shamt, f.funct};
  assign read_addr_1 = rs_addr;
  assign read_addr_2 = rt_addr;

  // Register 0 always reads as zero, even if write-back targets it.
  always_comb begin
    rs_val = read_data_1;
    rt_val = read_data_2;
    if (wb_reg_write && (wb_addr != '0) && (wb_addr == rs_addr)) rs_val = wb_data;
    if (wb_reg_write && (wb_addr != '0) && (wb_addr == rt_addr)) rt_val = wb_data;
    if (rs_addr == '0) rs_val = '0;
    if (rt_addr == '0) rt_val = '0;
  end

  always_comb begin
    dest_c = '0;
    if (ctrl.reg_write) dest_c = ctrl.dest_is_rd ? rd_addr : rt_addr;
  end

  always_comb begin
    out_d           = '0;
    out_d.valid     = 1'b1;
    out_d.illegal   = illegal;
    out_d.rs_data   = rs_val;
    out_d.rt_data   = rt_val;
    out_d.imm       = {{(DATA_W-16){imm16[15]}}, imm16};
    out_d.dest      = dest_c;
    out_d.reg_write = ctrl.reg_write && (dest_c != '0);
    out_d.mem_read  = ctrl.mem_read;
    out_d.mem_write = ctrl.mem_write;
    out_d.alu_src   = ctrl.alu_src;
    out_d.branch    = ctrl.branch;
    out_d.alu_op    = ctrl.alu_op;
  end

  assign hold     = out_q.valid && !out_ready;
  assign load_use = out_q.valid && out_q.mem_read && (out_q.dest != '0) &&
                    ((out_q.dest == rs_addr) || (ctrl.uses_rt && (out_q.dest == rt_addr)));
  assign in_ready = flush || !(hold || load_use);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_q <= '0;
    end else if (!hold) begin
      if (load_use || !in_valid) out_q <= '0;
      else                       out_q <= out_d;
    end
  end

  assign out_valid     = out_q.valid;
  assign out_illegal   = out_q.illegal;
  assign out_rs_data   = out_q.rs_data;
  assign out_rt_data   = out_q.rt_data;
  assign out_imm       = out_q.imm;
  assign out_dest      = out_q.dest;
  assign out_reg_write = out_q.reg_write;
  assign out_mem_read  = out_q.mem_read;
  assign out_mem_write = out_q.mem_write;
  assign out_alu_src   = out_q.alu_src;
  assign out_branch    = out_q.branch;
  assign out_alu_op    = out_q.alu_op;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table of decode vectors scored
// through an expectation queue, plus hand-written stall/hold/flush/reset cases.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_instr;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  read_addr_1, read_addr_2;
  logic [31:0] read_data_1, read_data_2;
  logic        wb_reg_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs_data, out_rt_data, out_imm;
  logic [4:0]  out_dest;
  logic        out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_branch;
  logic [2:0]  out_alu_op;
  logic        out_illegal;

  decode_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .in_instr(in_instr), .in_valid(in_valid), .in_ready(in_ready),
    .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
    .read_data_1(read_data_1), .read_data_2(read_data_2),
    .wb_reg_write(wb_reg_write), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_dest(out_dest), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .out_alu_src(out_alu_src), .out_branch(out_branch),
    .out_alu_op(out_alu_op), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // ctl packing: {reg_write, mem_read, mem_write, alu_src, branch, alu_op[2:0], illegal}
  typedef struct {
    logic [31:0] instr, rd1, rd2;
    logic        wbe;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic [31:0] rs, rt, imm;
    logic [4:0]  dest;
    logic [8:0]  ctl;
  } vec_t;

  typedef struct {
    logic [31:0] rs, rt, imm;
    logic [4:0]  dest;
    logic [8:0]  ctl;
  } exp_t;

  exp_t sbq[$];
  vec_t vt[12];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, rd1, rd2, input logic wbe,
                              input logic [4:0] wba, input logic [31:0] wbd,
                              input logic [31:0] rs, rt, imm, input logic [4:0] dest,
                              input logic [8:0] ctl);
    vec_t v;
    v.instr = instr; v.rd1 = rd1; v.rd2 = rd2; v.wbe = wbe; v.wba = wba; v.wbd = wbd;
    v.rs = rs; v.rt = rt; v.imm = imm; v.dest = dest; v.ctl = ctl;
    return v;
  endfunction

  function automatic exp_t mke(input logic [31:0] rs, rt, imm, input logic [4:0] dest,
                               input logic [8:0] ctl);
    exp_t e;
    e.rs = rs; e.rt = rt; e.imm = imm; e.dest = dest; e.ctl = ctl;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: an output is consumed when valid and ready are both high.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: got output dest %0d expected none at %0t", out_dest, $time);
      end else begin
        e = sbq.pop_front();
        chk("sb_rs_data", out_rs_data, e.rs);
        chk("sb_rt_data", out_rt_data, e.rt);
        chk("sb_imm", out_imm, e.imm);
        chk("sb_dest", {27'd0, out_dest}, {27'd0, e.dest});
        chk("sb_ctl", {23'd0, out_reg_write, out_mem_read, out_mem_write, out_alu_src,
                       out_branch, out_alu_op, out_illegal}, {23'd0, e.ctl});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = mk(32'h2005FFFD, 32'h11, 32'h22, 0, 5'd0, 32'h0,  32'h0,    32'h22,  32'hFFFFFFFD, 5'd5,  9'b1_0_0_1_0_000_0);
    vt[1]  = mk(32'h00861820, 32'h7,  32'h5,  1, 5'd4, 32'h9,  32'h9,    32'h5,   32'h00001820, 5'd3,  9'b1_0_0_0_0_000_0);
    vt[2]  = mk(32'h00223822, 32'h100,32'h200,1, 5'd2, 32'hAA, 32'h100,  32'hAA,  32'h00003822, 5'd7,  9'b1_0_0_0_0_001_0);
    vt[3]  = mk(32'h016C5024, 32'h1234,32'h5678,0,5'd11,32'h55,32'h1234, 32'h5678,32'h00005024, 5'd10, 9'b1_0_0_0_0_010_0);
    vt[4]  = mk(32'h00220025, 32'h3,  32'h4,  0, 5'd0, 32'h0,  32'h3,    32'h4,   32'h00000025, 5'd0,  9'b0_0_0_0_0_011_0);
    vt[5]  = mk(32'h0003202A, 32'h44, 32'h33, 1, 5'd0, 32'hFF, 32'h0,    32'h33,  32'h0000202A, 5'd4,  9'b1_0_0_0_0_100_0);
    vt[6]  = mk(32'h8C28FFFC, 32'h1000,32'h77,0, 5'd0, 32'h0,  32'h1000, 32'h77,  32'hFFFFFFFC, 5'd8,  9'b1_1_0_1_0_000_0);
    vt[7]  = mk(32'hAC490008, 32'h20, 32'h99, 0, 5'd0, 32'h0,  32'h20,   32'h99,  32'h00000008, 5'd0,  9'b0_0_1_1_0_000_0);
    vt[8]  = mk(32'h1064FFFF, 32'h5,  32'h5,  0, 5'd0, 32'h0,  32'h5,    32'h5,   32'hFFFFFFFF, 5'd0,  9'b0_0_0_0_1_001_0);
    vt[9]  = mk(32'hFC220000, 32'h11, 32'h22, 0, 5'd0, 32'h0,  32'h11,   32'h22,  32'h00000000, 5'd0,  9'b0_0_0_0_0_000_1);
    vt[10] = mk(32'h00221821, 32'h10, 32'h20, 0, 5'd0, 32'h0,  32'h10,   32'h20,  32'h00001821, 5'd0,  9'b0_0_0_0_0_000_1);
    vt[11] = mk(32'h20A00001, 32'h50, 32'h60, 0, 5'd0, 32'h0,  32'h50,   32'h0,   32'h00000001, 5'd0,  9'b0_0_0_1_0_000_0);

    reset = 1'b1; in_instr = '0; in_valid = 1'b0; read_data_1 = '0; read_data_2 = '0;
    wb_reg_write = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_illegal", out_illegal, 0);
    chk("rst_rs_data", out_rs_data, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_ctl", {out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_branch, out_alu_op, out_dest}, 0);
    chk("rst_in_ready", in_ready, 1);
    tick();

    // Back-to-back table vectors.
    for (int i = 0; i < 12; i++) begin
      in_instr = vt[i].instr; read_data_1 = vt[i].rd1; read_data_2 = vt[i].rd2;
      wb_reg_write = vt[i].wbe; wb_addr = vt[i].wba; wb_data = vt[i].wbd; in_valid = 1'b1;
      @(negedge clk);
      chk("vec_in_ready", in_ready, 1);
      chk("vec_read_addr_1", {27'd0, read_addr_1}, {27'd0, vt[i].instr[25:21]});
      chk("vec_read_addr_2", {27'd0, read_addr_2}, {27'd0, vt[i].instr[20:16]});
      sbq.push_back(mke(vt[i].rs, vt[i].rt, vt[i].imm, vt[i].dest, vt[i].ctl));
      tick();
    end
    in_valid = 1'b0; wb_reg_write = 1'b0;
    tick();
    chk("vec_drain", sbq.size(), 0);

    // Load-use: lw $8,0($1) then add $9,$8,$2.
    read_data_1 = 32'h3; read_data_2 = 32'h4;
    in_instr = 32'h8C280000; in_valid = 1'b1;
    @(negedge clk);
    sbq.push_back(mke(32'h3, 32'h4, 32'h0, 5'd8, 9'b1_1_0_1_0_000_0));
    tick();
    in_instr = 32'h01024820;
    @(negedge clk);
    chk("lu_in_ready_low", in_ready, 0);
    tick();
    @(negedge clk);
    chk("lu_bubble", out_valid, 0);
    chk("lu_in_ready_high", in_ready, 1);
    sbq.push_back(mke(32'h3, 32'h4, 32'h00004820, 5'd9, 9'b1_0_0_0_0_000_0));
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lu_add_dest", {27'd0, out_dest}, 32'd9);
    tick();

    // Downstream hold for 3 cycles.
    in_instr = 32'h00223822; read_data_1 = 32'h100; read_data_2 = 32'h200; in_valid = 1'b1;
    @(negedge clk);
    sbq.push_back(mke(32'h100, 32'h200, 32'h00003822, 5'd7, 9'b1_0_0_0_0_001_0));
    tick();
    in_valid = 1'b0; out_ready = 1'b0; read_data_1 = 32'hDEAD; read_data_2 = 32'hBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_rs_data", out_rs_data, 32'h100);
      chk("hold_dest", {27'd0, out_dest}, 32'd7);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("hold_issued_once", out_valid, 0);
    chk("hold_drain", sbq.size(), 0);
    tick();

    // Flush kills the instruction being decoded.
    in_instr = 32'h00223822; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_kill", out_valid, 0);
    tick();

    // Flush drops a held output.
    in_instr = 32'h2005FFFD; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("flush_held_valid", out_valid, 1);
    tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_hold_in_ready", in_ready, 1);
    tick();
    flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_drop", out_valid, 0);
    tick();

    // Reset during a load-use stall.
    read_data_1 = 32'h3; read_data_2 = 32'h4;
    in_instr = 32'h8C280000; in_valid = 1'b1;
    tick();
    in_instr = 32'h01024820; reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("rst_stall_valid", out_valid, 0);
    chk("rst_stall_mem_read", out_mem_read, 0);
    chk("rst_stall_dest", {27'd0, out_dest}, 0);
    chk("rst_stall_rs_data", out_rs_data, 0);
    chk("rst_stall_in_ready", in_ready, 1);
    tick();
    @(negedge clk);
    chk("rst_no_replay", out_valid, 0);
    chk("final_drain", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32: register/operand width.
REQ-002 Parameter ADDR_W, default 5: register address width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_instr  input  32  instruction from fetch.
REQ-006 in_valid / in_ready  input / output  1 / 1  fetch handshake; instruction accepted when both high at a rising edge.
REQ-007 read_addr_1, read_addr_2  output  ADDR_W  register file read addresses, combinational from in_instr.
REQ-008 read_data_1, read_data_2  input  DATA_W  register file read data, combinational.
REQ-009 wb_reg_write, wb_addr, wb_data  input  1, ADDR_W, DATA_W  write-back port driving the register file this cycle.
REQ-010 flush  input  1  branch redirect; kills the instruction being decoded.
REQ-011 out_valid / out_ready  output / input  1 / 1  execute handshake.
REQ-012 out_rs_data, out_rt_data, out_imm  output  DATA_W each  operands and sign-extended immediate.
REQ-013 out_dest  output  ADDR_W; out_reg_write, out_mem_read, out_mem_write, out_alu_src, out_branch  output  1 each; out_alu_op  output  3.
REQ-014 out_illegal  output  1  registered; high with out_valid for an undecodable opcode or funct.

Function
REQ-015 Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0]; read_addr_1=rs, read_addr_2=rt.
REQ-016 Supported: R-type (opcode 0; funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A), addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
REQ-017 dest = rd for R-type, rt for addi/lw; reg_write=0 for sw/beq; dest forced to 0 and reg_write to 0 when the computed dest is 0.
REQ-018 out_imm = imm sign-extended to DATA_W; alu_src=1 for addi/lw/sw.
REQ-019 Illegal opcode/funct: emit out_valid=1, out_illegal=1, all write/memory controls 0.
REQ-020 WB bypass: when wb_reg_write=1, wb_addr!=0 and wb_addr equals rs (or rt), the operand is taken from wb_data instead of read_data.
REQ-021 Reads of address 0 yield 0 regardless of read_data or the bypass.
REQ-022 Latency: an accepted instruction appears on the outputs exactly 1 cycle later; outputs are fully registered.
REQ-023 Hold: when out_valid=1 and out_ready=0, all outputs hold and in_ready=0.
REQ-024 Load-use: when out_valid=1, out_mem_read=1, out_dest!=0 and out_dest matches rs, or rt for R-type/sw/beq, then in_ready=0 and a bubble (out_valid=0) issues at the next edge where out_ready=1; the instruction is accepted on the following cycle.
REQ-025 Flush: when flush=1, in_ready=1; the input is discarded and out_valid=0 next cycle; a held output is also dropped.
REQ-026 Priority: reset > flush > downstream hold > load-use bubble > normal capture.
REQ-027 With in_valid=0 and no hold, out_valid=0 next cycle (bubble).

Reset
REQ-028 At a reset edge: out_valid=0, out_illegal=0, all data/control outputs 0; in_ready=1 on the first cycle after reset.
REQ-029 Reset mid-stall or mid-hold discards all pending state; no instruction is replayed.

Structure
REQ-030 Opcode/funct constants, the alu_op encoding (ADD=0, SUB=1, AND=2, OR=3, SLT=4) and a decoded-control struct reside in shared package cpu_pkg.
REQ-031 Combinational decode is a sub-module, instr_decoder (instr in, control struct plus illegal out); hazard, bypass and output registers stay in decode_stage.

Verification
REQ-032 addi $5,$0,-3 (0x2005FFFD), out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFD, out_dest=5, out_alu_src=1, out_alu_op=ADD.
REQ-033 add $3,$4,$6 with read_data_1=7 and wb_reg_write=1, wb_addr=4, wb_data=9 -> out_rs_data=9.
REQ-034 lw $8,0($1) followed by add $9,$8,$2 -> one cycle in_ready=0, one bubble, then add is issued with out_dest=9.
REQ-035 out_ready=0 for 3 cycles with valid output -> outputs stable, in_ready=0; the instruction is issued once after release.
REQ-036 flush=1 during an in_valid sub -> out_valid=0 next cycle; opcode 0x3F -> out_illegal=1, out_reg_write=0.
REQ-037 reset asserted during a load-use stall -> all outputs 0 next cycle, in_ready=1.
